alu_pipe: RTL and testbench

Parametrised, two-stage pipelined Hack-style ALU with valid/ready handshakes on input and output, status flags, and an internal accumulator that can replace the y operand. It succeeds the combinational 16-bit ALU as the datapath execute unit. Operands and six Hack control bits enter through a handshake, and results with flags leave through a handshake under downstream backpressure.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_core.sv | 29 ++
 rtl/alu_pipe.sv | 140 ++++++++++++++
 tb/tb_alu_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the pipelined Hack ALU: control bundle, flag bundle, standard function encodings.
// Control encodings are ordered {zx, nx, zy, ny, f, no}.
package alu_pkg;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  typedef struct packed {
    logic zr;
    logic ng;
    logic co;
    logic ov;
  } alu_flags_t;

  localparam alu_ctrl_t ZERO      = 6'b101010;
  localparam alu_ctrl_t ONE       = 6'b111111;
  localparam alu_ctrl_t NEG_ONE   = 6'b111010;
  localparam alu_ctrl_t X         = 6'b001100;
  localparam alu_ctrl_t Y         = 6'b110000;
  localparam alu_ctrl_t NOT_X     = 6'b001101;
  localparam alu_ctrl_t NOT_Y     = 6'b110001;
  localparam alu_ctrl_t NEG_X     = 6'b001111;
  localparam alu_ctrl_t NEG_Y     = 6'b110011;
  localparam alu_ctrl_t X_PLUS_1  = 6'b011111;
  localparam alu_ctrl_t Y_PLUS_1  = 6'b110111;
  localparam alu_ctrl_t X_MINUS_1 = 6'b001110;
  localparam alu_ctrl_t Y_MINUS_1 = 6'b110010;
  localparam alu_ctrl_t X_PLUS_Y  = 6'b000010;
  localparam alu_ctrl_t X_MINUS_Y = 6'b010011;
  localparam alu_ctrl_t Y_MINUS_X = 6'b000111;
  localparam alu_ctrl_t X_AND_Y   = 6'b000000;
  localparam alu_ctrl_t X_OR_Y    = 6'b010101;

endpackage

// File: rtl/alu_core.sv
// Combinational f/no stage of the Hack ALU with zero/negative/carry/overflow flags.
// Carry and overflow describe the raw xp+yp sum, taken before the output inversion.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] xp,
  input  logic [WIDTH-1:0] yp,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] res,
  output alu_flags_t       flags
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] raw;

  always_comb begin
    sum      = {1'b0, xp} + {1'b0, yp};
    raw      = f ? sum[WIDTH-1:0] : (xp & yp);
    res      = no ? ~raw : raw;
    flags.zr = (res == '0);
    flags.ng = res[WIDTH-1];
    flags.co = f & sum[WIDTH];
    flags.ov = f & (xp[WIDTH-1] == yp[WIDTH-1]) & (sum[WIDTH-1] != xp[WIDTH-1]);
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage Hack ALU with valid/ready on both sides and an accumulator that can stand in for y.
// Result two edges after acceptance; acc_sel beats stall until the pipeline drains so they see the last result.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic             acc_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             co,
  output logic             ov
);

  alu_ctrl_t ctrl;

  logic             s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0] s1_xp_q, s1_xp_d;
  logic [WIDTH-1:0] s1_yp_q, s1_yp_d;
  logic             s1_f_q, s1_f_d;
  logic             s1_no_q, s1_no_d;

  logic             s2_vld_q, s2_vld_d;
  logic [WIDTH-1:0] s2_res_q, s2_res_d;
  alu_flags_t       s2_flags_q, s2_flags_d;

  logic [WIDTH-1:0] acc_q, acc_d;

  logic             s2_load;
  logic             hazard;
  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] core_res;
  alu_flags_t       core_flags;

  assign ctrl = {zx, nx, zy, ny, f, no};

  function automatic logic [WIDTH-1:0] prep(input logic [WIDTH-1:0] v, input logic z, input logic n);
    logic [WIDTH-1:0] t;
    t = z ? '0 : v;
    return n ? ~t : t;
  endfunction

  alu_core #(.WIDTH(WIDTH)) u_core (
    .xp    (s1_xp_q),
    .yp    (s1_yp_q),
    .f     (s1_f_q),
    .no    (s1_no_q),
    .res   (core_res),
    .flags (core_flags)
  );

  always_comb begin
    s2_load  = !s2_vld_q || out_ready;
    hazard   = s1_vld_q || s2_vld_q;
    // acc_sel waits for a fully empty pipe so acc already holds the newest result
    in_ready = (!s1_vld_q || s2_load) && !(acc_sel && hazard);
    in_fire  = in_valid && in_ready;
    out_fire = s2_vld_q && out_ready;

    s1_vld_d   = s1_vld_q;
    s1_xp_d    = s1_xp_q;
    s1_yp_d    = s1_yp_q;
    s1_f_d     = s1_f_q;
    s1_no_d    = s1_no_q;
    s2_vld_d   = s2_vld_q;
    s2_res_d   = s2_res_q;
    s2_flags_d = s2_flags_q;
    acc_d      = acc_q;

    if (in_fire) begin
      s1_vld_d = 1'b1;
      s1_xp_d  = prep(x, ctrl.zx, ctrl.nx);
      s1_yp_d  = prep(acc_sel ? acc_q : y, ctrl.zy, ctrl.ny);
      s1_f_d   = ctrl.f;
      s1_no_d  = ctrl.no;
    end else if (s2_load) begin
      s1_vld_d = 1'b0;
    end

    if (s2_load) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_res_d   = core_res;
        s2_flags_d = core_flags;
      end
    end

    if (out_fire) begin
      acc_d = s2_res_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_xp_q    <= '0;
      s1_yp_q    <= '0;
      s1_f_q     <= 1'b0;
      s1_no_q    <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_res_q   <= '0;
      s2_flags_q <= '0;
      acc_q      <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_xp_q    <= s1_xp_d;
      s1_yp_q    <= s1_yp_d;
      s1_f_q     <= s1_f_d;
      s1_no_q    <= s1_no_d;
      s2_vld_q   <= s2_vld_d;
      s2_res_q   <= s2_res_d;
      s2_flags_q <= s2_flags_d;
      acc_q      <= acc_d;
    end
  end

  assign out_valid = s2_vld_q;
  assign out       = s2_res_q;
  assign zr        = s2_flags_q.zr;
  assign ng        = s2_flags_q.ng;
  assign co        = s2_flags_q.co;
  assign ov        = s2_flags_q.ov;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vectors plus a randomized run scored against an arithmetic reference model.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] x, y, out;
  logic         zx, nx, zy, ny, f, no, acc_sel;
  logic         zr, ng, co, ov;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] out;
    logic [3:0]   fl;
    int           acc_cyc;
  } exp_t;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .acc_sel(acc_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zr(zr), .ng(ng), .co(co), .ov(ov)
  );

  // Plain integer arithmetic; overflow judged by the signed sum leaving the representable range.
  function automatic exp_t model(input logic [W-1:0] xi, input logic [W-1:0] yi,
                                 input logic [W-1:0] ai, input logic sel, input logic [5:0] c);
    exp_t e;
    longint unsigned m, a, b, s, r;
    longint sa, sb, ss;
    m = (64'd1 << W) - 64'd1;
    a = c[5] ? 64'd0 : 64'(xi);
    if (c[4]) a = ~a & m;
    b = c[3] ? 64'd0 : (sel ? 64'(ai) : 64'(yi));
    if (c[2]) b = ~b & m;
    s = a + b;
    r = c[1] ? (s & m) : (a & b);
    if (c[0]) r = ~r & m;
    sa = (a > (m >> 1)) ? longint'(a) - longint'(m + 64'd1) : longint'(a);
    sb = (b > (m >> 1)) ? longint'(b) - longint'(m + 64'd1) : longint'(b);
    ss = sa + sb;
    e.out = r[W-1:0];
    e.fl  = {r == 64'd0, r > (m >> 1), c[1] && (s > m),
             c[1] && ((ss > longint'(m >> 1)) || (ss < -longint'((m >> 1) + 64'd1)))};
    e.acc_cyc = 0;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] xi, input logic [W-1:0] yi,
                       input logic [5:0] c, input logic sel);
    in_valid = v;
    x = xi;
    y = yi;
    {zx, nx, zy, ny, f, no} = c;
    acc_sel = sel;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, 6'b0, 1'b0);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out !== '0) begin bad++; $display("FAIL reset_out got=%h want=0000", out); end
    total++; if ({zr, ng, co, ov} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {zr, ng, co, ov}); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_directed();
    logic [W-1:0] tx [5] = '{16'h0008, 16'h0008, 16'hFFFF, 16'h7FFF, 16'h0008};
    logic [W-1:0] ty [5] = '{16'h0018, 16'h0018, 16'h0001, 16'h0001, 16'h0018};
    logic [5:0]   tc [5] = '{6'b111100, 6'b000010, 6'b000010, 6'b000010, 6'b010011};
    logic [W-1:0] to [5] = '{16'hFFFF, 16'h0020, 16'h0000, 16'h8000, 16'hFFF0};
    logic [3:0]   tf [5] = '{4'b0100, 4'b0000, 4'b1010, 4'b0101, 4'b0110};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      drive(1'b1, tx[i], ty[i], tc[i], 1'b0);
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL dir%0d_accept got=%b want=1", i, in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_early_valid got=%b want=0", i, out_valid); end
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL dir%0d_latency got=%b want=1", i, out_valid); end
      total++; if (out !== to[i]) begin bad++; $display("FAIL dir%0d_out got=%h want=%h", i, out, to[i]); end
      total++; if ({zr, ng, co, ov} !== tf[i]) begin bad++; $display("FAIL dir%0d_flags got=%b want=%b", i, {zr, ng, co, ov}, tf[i]); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t ea, eb;
    ea = model(16'h0008, 16'h0018, '0, 1'b0, X_PLUS_Y);
    eb = model(16'h0008, 16'h0018, '0, 1'b0, X_MINUS_Y);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(1'b1, 16'h0008, 16'h0018, X_PLUS_Y, 1'b0);
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_accept_a got=%b want=1", in_ready); end
    @(posedge clk); #1;
    drive(1'b1, 16'h0008, 16'h0018, X_MINUS_Y, 1'b0);
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_accept_b got=%b want=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++; if ({out_valid, out, zr, ng, co, ov} !== {1'b1, 16'h0020, ea.fl}) begin
      bad++; $display("FAIL b2b_first got=%b/%h/%b want=1/0020/%b", out_valid, out, {zr, ng, co, ov}, ea.fl);
    end
    @(negedge clk);
    total++; if ({out_valid, out, ng} !== {1'b1, 16'hFFF0, 1'b1}) begin
      bad++; $display("FAIL b2b_second got=%b/%h/ng%b want=1/fff0/ng1", out_valid, out, ng);
    end
    total++; if ({zr, ng, co, ov} !== eb.fl) begin bad++; $display("FAIL b2b_second_flags got=%b want=%b", {zr, ng, co, ov}, eb.fl); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b want=0", out_valid); end
  endtask

  task automatic test_backpressure();
    exp_t         e [3];
    logic [W-1:0] hx [3];
    logic [W-1:0] hy [3];
    logic [W-1:0] held_out;
    logic [3:0]   held_fl;
    bit           seen = 1'b0;
    int           acc_n = 0;
    int           rcv = 0;
    for (int i = 0; i < 3; i++) begin
      hx[i] = W'($urandom);
      hy[i] = W'($urandom);
      e[i]  = model(hx[i], hy[i], '0, 1'b0, X_PLUS_Y);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(1'b1, hx[0], hy[0], X_PLUS_Y, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (!seen) begin
          seen = 1'b1; held_out = out; held_fl = {zr, ng, co, ov};
        end else begin
          total++;
          if ({out, zr, ng, co, ov} !== {held_out, held_fl}) begin
            bad++; $display("FAIL bp_hold_stable got=%h/%b want=%h/%b", out, {zr, ng, co, ov}, held_out, held_fl);
          end
        end
      end
      if (in_valid && in_ready) acc_n++;
      @(posedge clk); #1;
      if (acc_n < 3) drive(1'b1, hx[acc_n], hy[acc_n], X_PLUS_Y, 1'b0);
    end
    @(negedge clk);
    total++; if (acc_n !== 2) begin bad++; $display("FAIL bp_accept_count got=%0d want=2", acc_n); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
    total++; if ({out_valid, out, zr, ng, co, ov} !== {1'b1, e[0].out, e[0].fl}) begin
      bad++; $display("FAIL bp_held_value got=%b/%h/%b want=1/%h/%b", out_valid, out, {zr, ng, co, ov}, e[0].out, e[0].fl);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && rcv < 3; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        total++;
        if ({out, zr, ng, co, ov} !== {e[rcv].out, e[rcv].fl}) begin
          bad++; $display("FAIL bp_drain%0d got=%h/%b want=%h/%b", rcv, out, {zr, ng, co, ov}, e[rcv].out, e[rcv].fl);
        end
        rcv++;
      end
      if (in_valid && in_ready) acc_n++;
      @(posedge clk); #1;
      if (acc_n >= 3) in_valid = 1'b0;
      else drive(1'b1, hx[acc_n], hy[acc_n], X_PLUS_Y, 1'b0);
    end
    total++; if (rcv !== 3) begin bad++; $display("FAIL bp_received got=%0d want=3", rcv); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_duplicate got=%b want=0", out_valid); end
  endtask

  task automatic test_acc();
    logic [W-1:0] res [2];
    int stalls = 0;
    int got = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(1'b1, 16'd5, 16'd3, X_PLUS_Y, 1'b0);
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL acc_accept_first got=%b want=1", in_ready); end
    @(posedge clk); #1;
    drive(1'b1, 16'd1, 16'h7777, X_PLUS_Y, 1'b1);
    for (int c = 0; c < 15 && got < 2; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin res[got] = out; got++; end
      if (in_valid) begin
        if (in_ready) begin
          @(posedge clk); #1;
          drive(1'b0, '0, '0, 6'b0, 1'b0);
        end else begin
          stalls++;
          @(posedge clk); #1;
        end
      end else begin
        @(posedge clk); #1;
      end
    end
    total++; if (stalls !== 2) begin bad++; $display("FAIL acc_bubbles got=%0d want=2", stalls); end
    total++; if (got !== 2) begin bad++; $display("FAIL acc_results got=%0d want=2", got); end
    if (got == 2) begin
      total++; if (res[0] !== 16'd8) begin bad++; $display("FAIL acc_first got=%h want=0008", res[0]); end
      total++; if (res[1] !== 16'd9) begin bad++; $display("FAIL acc_second got=%h want=0009", res[1]); end
    end
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(1'b1, 16'h1111, 16'h2222, X_PLUS_Y, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    drive(1'b1, 16'h3333, 16'h4444, X_OR_Y, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 6'b0, 1'b0);
    #2;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_inflight_before got=%b want=1", out_valid); end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_async_valid got=%b want=0", out_valid); end
    total++; if ({out, zr, ng, co, ov} !== 20'h0) begin bad++; $display("FAIL rst_async_out got=%h/%b want=0000/0000", out, {zr, ng, co, ov}); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_stale%0d got=%b want=0", c, out_valid); end
    end
    // Y with acc_sel returns acc itself, exposing the cleared accumulator
    @(posedge clk); #1;
    drive(1'b1, 16'hABCD, 16'h1234, Y, 1'b1);
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_new_accept got=%b want=1", in_ready); end
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 6'b0, 1'b0);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_new_early got=%b want=0", out_valid); end
    @(negedge clk);
    total++; if ({out_valid, out, zr} !== {1'b1, 16'h0000, 1'b1}) begin
      bad++; $display("FAIL rst_acc_cleared got=%b/%h/zr%b want=1/0000/zr1", out_valid, out, zr);
    end
  endtask

  task automatic test_random();
    exp_t         q [$];
    exp_t         e;
    logic [W-1:0] macc = '0;
    logic [W-1:0] pool [5] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001};
    logic         exp_rdy, exp_vld;
    int           cyc = 0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      cyc++;
      out_ready = ($urandom_range(9) < 7);
      drive($urandom_range(9) < 7,
            ($urandom_range(3) == 0) ? pool[$urandom_range(4)] : W'($urandom),
            ($urandom_range(3) == 0) ? pool[$urandom_range(4)] : W'($urandom),
            6'($urandom), $urandom_range(6) == 0);
      @(negedge clk);
      exp_rdy = acc_sel ? (q.size() == 0) : (q.size() < 2 || out_ready);
      exp_vld = (q.size() > 0) && (cyc - q[0].acc_cyc >= 1);
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL rnd_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, exp_rdy); end
      total++; if (out_valid !== exp_vld) begin bad++; $display("FAIL rnd_out_valid cyc=%0d got=%b want=%b", cyc, out_valid, exp_vld); end
      if (out_valid === 1'b1 && q.size() > 0) begin
        total++;
        if ({out, zr, ng, co, ov} !== {q[0].out, q[0].fl}) begin
          bad++; $display("FAIL rnd_result cyc=%0d got=%h/%b want=%h/%b", cyc, out, {zr, ng, co, ov}, q[0].out, q[0].fl);
        end
        if (out_ready) begin
          macc = q[0].out;
          void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        e = model(x, y, macc, acc_sel, {zx, nx, zy, ny, f, no});
        e.acc_cyc = cyc + 1;
        q.push_back(e);
      end
    end
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 6'b0, 1'b0);
    out_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        total++;
        if ({out, zr, ng, co, ov} !== {q[0].out, q[0].fl}) begin
          bad++; $display("FAIL rnd_drain got=%h/%b want=%h/%b", out, {zr, ng, co, ov}, q[0].out, q[0].fl);
        end
        void'(q.pop_front());
      end
      @(posedge clk); #1;
    end
    total++; if (q.size() !== 0) begin bad++; $display("FAIL rnd_left_over got=%0d want=0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_acc();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
